// File: rtl/main_memory_burst_ctrl.sv
// Word-organised single-port main memory with request/ready handshake,
// fixed SRAM access latency, incrementing bursts and sub-word read-modify-write.
module main_memory_burst_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BURST_W     = 3,
    localparam int unsigned BYTES      = DATA_W / 8,
    localparam int unsigned OFS_W      = $clog2(BYTES),
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               rd_wr,
    input  logic [OFS_W-1:0]   wr_size,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DATA_W-1:0]  wdata,
    output logic               ready,
    output logic [DATA_W-1:0]  rdata,
    output logic               rvalid,
    output logic               wack,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] beat_q, beat_d, len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OFS_W-1:0]   ofs_q, ofs_d, size_q, size_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d, merge_q, merge_d, rdata_d;
    logic [DATA_W-1:0]  mem_wdata, merged, shifted;
    logic               ready_d, rvalid_d, wack_d, done_d, err_d;
    logic               mem_we, cnt_last, req_bad, first_new_beat;
    logic [OFS_W:0]     end_ofs;
    logic               unused_addr_hi;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Upper address bits alias onto the same words.
    assign unused_addr_hi = ^addr[ADDR_W-1:OFS_W+IDX_W];

    assign cnt_last       = (cnt_q == CNT_W'(WAIT_CYCLES));
    assign first_new_beat = (cnt_q == '0) && (beat_q != '0);
    assign end_ofs        = {1'b0, addr[OFS_W-1:0]} + {1'b0, wr_size};
    assign req_bad        = ((wr_size != '0) && (burst_len != '0))
                          || (end_ofs > (OFS_W+1)'(BYTES))
                          || ((wr_size == '0) && (addr[OFS_W-1:0] != '0));

    // Lane merge: wdata lanes 0.. land at byte offset ofs_q in the word.
    always_comb begin
        shifted = wdata_q << {ofs_q, 3'b000};
        merged  = merge_q;
        for (int k = 0; k < int'(BYTES); k++) begin
            if ((k >= int'(ofs_q)) && (k < int'(ofs_q) + int'(size_q))) begin
                merged[8*k +: 8] = shifted[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        ofs_d     = ofs_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata;
        ready_d   = ready;
        rvalid_d  = 1'b0;
        wack_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (en) begin
                    idx_d   = addr[OFS_W +: IDX_W];
                    ofs_d   = addr[OFS_W-1:0];
                    size_d  = wr_size;
                    len_d   = burst_len;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    beat_d  = '0;
                    ready_d = 1'b0;
                    if (!rd_wr) begin
                        state_d = S_RD;
                    end else if (req_bad) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if (wr_size == '0) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    rdata_d  = mem[idx_q];
                    rvalid_d = 1'b1;
                    cnt_d    = '0;
                    if (beat_q == len_q) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Later beats take fresh wdata on their first cycle.
                if (first_new_beat) begin
                    wdata_d   = wdata;
                    mem_wdata = wdata;
                end
                if (cnt_last) begin
                    mem_we = 1'b1;
                    wack_d = 1'b1;
                    cnt_d  = '0;
                    if (beat_q == len_q) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BURST_W'(1);
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            S_RMW_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    merge_d = mem[idx_q];
                    cnt_d   = '0;
                    state_d = S_RMW_WR;
                end
            end
            S_RMW_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    mem_we    = 1'b1;
                    mem_wdata = merged;
                    wack_d    = 1'b1;
                    done_d    = 1'b1;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end
            end
            S_ERR: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ofs_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata   <= '0;
            ready   <= 1'b1;
            rvalid  <= 1'b0;
            wack    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ofs_q   <= ofs_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata   <= rdata_d;
            ready   <= ready_d;
            rvalid  <= rvalid_d;
            wack    <= wack_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_main_memory_burst_ctrl.sv
// Bench for main_memory_burst_ctrl: directed scenarios plus randomized
// transactions checked cycle by cycle against a word-array reference model.
module tb_main_memory_burst_ctrl;

    localparam int W     = 2;
    localparam int DEPTH = 1024;
    localparam int PER   = W + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        rd_wr = 1'b0;
    logic [1:0]  wr_size = '0;
    logic [31:0] addr = '0;
    logic [2:0]  burst_len = '0;
    logic [31:0] wdata = '0;
    logic        ready, rvalid, wack, done, err;
    logic [31:0] rdata;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wbeat [8];
    logic [31:0] last_rd = '0;
    bit          noise = 1'b0;

    main_memory_burst_ctrl #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(W), .BURST_W(3)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .rd_wr(rd_wr), .wr_size(wr_size),
        .addr(addr), .burst_len(burst_len), .wdata(wdata), .ready(ready),
        .rdata(rdata), .rvalid(rvalid), .wack(wack), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: expected pulses derived from the latency rules,
    // memory effects applied to the reference array.
    task automatic run_txn(input logic rw, input logic [1:0] size, input logic [31:0] a,
                           input logic [2:0] len);
        int         nb, klast, kind, beat;
        logic [9:0] idx, bi;
        logic [1:0] ofs;
        logic [31:0] w;
        bit         pulse;
        logic [4:0] ef;
        nb  = int'(len) + 1;
        idx = a[11:2];
        ofs = a[1:0];
        if (!rw) kind = 0;
        else if ((size != 0 && len != 0) || (int'(ofs) + int'(size) > 4) || (size == 0 && ofs != 0)) kind = 3;
        else if (size == 0) kind = 1;
        else kind = 2;
        klast = (kind == 0 || kind == 1) ? PER * nb : (kind == 2) ? 2 * PER : 0;

        check("ready_before_req", {63'd0, ready}, 64'd1);
        en = 1'b1; rd_wr = rw; wr_size = size; addr = a; burst_len = len; wdata = wbeat[0];
        @(posedge clk); #1;
        en = 1'b0;
        for (int k = 0; k <= klast + 1; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            pulse = (k > 0) && (k % PER == 0) && (k / PER <= nb);
            beat  = k / PER - 1;
            bi    = idx + 10'(beat);
            ef[4] = (kind == 3) ? (k >= 1) : (k >= klast);
            ef[3] = (kind == 0) && pulse;
            ef[2] = ((kind == 1) && pulse) || ((kind == 2) && (k == klast));
            ef[1] = (kind == 3) ? (k == 0) : (k == klast);
            ef[0] = (kind == 3) && (k == 0);
            if (ef[3]) last_rd = ref_mem[bi];
            check("flags_rdy_rv_wk_dn_er", {59'd0, ready, rvalid, wack, done, err}, {59'd0, ef});
            check("rdata", {32'd0, rdata}, {32'd0, last_rd});
            if ((kind == 1) && pulse) begin
                ref_mem[bi] = wbeat[beat];
                if (beat + 1 < nb) wdata = wbeat[beat + 1];
            end
            if (noise && (k < klast)) begin
                en = 1'(($urandom));
                rd_wr = 1'($urandom);
                addr = $urandom;
            end else begin
                en = 1'b0;
            end
        end
        if (kind == 2) begin
            w = wbeat[0];
            for (int b = 0; b < int'(size); b++) ref_mem[idx][8*(int'(ofs)+b) +: 8] = w[8*b +: 8];
        end
    endtask

    initial begin
        logic [1:0]  rs;
        logic [2:0]  rl;
        logic [31:0] ra;
        logic        rw;

        #12;
        check("reset_flags", {59'd0, ready, rvalid, wack, done, err}, 64'h10);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Preload the whole array so every later read has a defined model value.
        for (int i = 0; i < DEPTH / 8; i++) begin
            for (int j = 0; j < 8; j++) wbeat[j] = $urandom;
            run_txn(1'b1, 2'd0, 32'(i * 32), 3'd7);
        end

        wbeat[0] = 32'hDEADBEEF;
        run_txn(1'b1, 2'd0, 32'h40, 3'd0);
        run_txn(1'b0, 2'd0, 32'h40, 3'd0);
        check("read_deadbeef", {32'd0, rdata}, 64'hDEADBEEF);

        wbeat[0] = 32'h11223344;
        run_txn(1'b1, 2'd0, 32'h80, 3'd0);
        wbeat[0] = 32'h0000AABB;
        run_txn(1'b1, 2'd2, 32'h81, 3'd0);
        run_txn(1'b0, 2'd0, 32'h80, 3'd0);
        check("rmw_merge", {32'd0, rdata}, 64'h11AABB44);

        for (int j = 0; j < 4; j++) wbeat[j] = 32'(j + 1);
        run_txn(1'b1, 2'd0, 32'h100, 3'd3);
        run_txn(1'b0, 2'd0, 32'h100, 3'd3);
        check("burst_last", {32'd0, rdata}, 64'd4);

        for (int j = 0; j < 4; j++) wbeat[j] = 32'hA0 + 32'(j);
        run_txn(1'b1, 2'd0, 32'((DEPTH - 2) * 4), 3'd3);
        run_txn(1'b0, 2'd0, 32'((DEPTH - 2) * 4), 3'd3);
        run_txn(1'b0, 2'd0, 32'h0, 3'd0);
        check("wrap_word0", {32'd0, rdata}, 64'hA2);

        wbeat[0] = 32'h55555555;
        run_txn(1'b1, 2'd3, 32'h102, 3'd0);
        run_txn(1'b1, 2'd0, 32'h42, 3'd0);
        run_txn(1'b1, 2'd1, 32'h40, 3'd2);
        run_txn(1'b0, 2'd0, 32'h40, 3'd0);
        check("err_keeps_40", {32'd0, rdata}, 64'hDEADBEEF);
        run_txn(1'b0, 2'd0, 32'h100, 3'd0);
        check("err_keeps_100", {32'd0, rdata}, 64'd1);

        // Reset during the write-back phase of a byte write.
        wbeat[0] = 32'h11223344;
        run_txn(1'b1, 2'd0, 32'h80, 3'd0);
        en = 1'b1; rd_wr = 1'b1; wr_size = 2'd1; addr = 32'h80; burst_len = 3'd0; wdata = 32'h99;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (PER + 1) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_flags", {59'd0, ready, rvalid, wack, done, err}, 64'h10);
        check("midrst_rdata", {32'd0, rdata}, 64'd0);
        last_rd = '0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 2'd0, 32'h80, 3'd0);
        check("midrst_old_word", {32'd0, rdata}, 64'h11223344);

        noise = 1'b1;
        for (int t = 0; t < 150; t++) begin
            rw = 1'($urandom);
            rs = 2'($urandom);
            rl = 3'($urandom);
            ra = $urandom;
            if (rw && (rs != 0) && ($urandom_range(0, 3) != 0)) rl = 3'd0;
            if (rw && (rs == 0) && ($urandom_range(0, 3) != 0)) ra[1:0] = 2'd0;
            for (int j = 0; j < 8; j++) wbeat[j] = $urandom;
            run_txn(rw, rs, ra, rl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/main_memory_burst_ctrl.md
Name: main_memory_burst_ctrl

Overview:
Parametrised next-generation main memory block.
- Single-port word-organised store with a request/ready handshake and a configurable SRAM access latency.
- Supports multi-beat incrementing bursts, and sub-word writes via internal read-modify-write.
- Sits behind the cache/bus interface in the memory subsystem, replacing the fixed 32-bit single-beat main memory.

Parameters:
DATA_W, 32, word width in bits; multiple of 8; BYTES = DATA_W/8, OFS_W = clog2(BYTES)
DEPTH, 1024, number of words; power of two; IDX_W = clog2(DEPTH)
ADDR_W, 32, byte address width
WAIT_CYCLES, 2, extra cycles per SRAM access; each access takes WAIT_CYCLES+1 cycles
BURST_W, 3, width of burst_len; max burst = 2^BURST_W beats

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  request valid; sampled only while ready=1
rd_wr  in  1  1 = write, 0 = read
wr_size  in  OFS_W  write byte count; 0 = full word, k = k bytes (1..BYTES-1)
addr  in  ADDR_W  byte start address
burst_len  in  BURST_W  beats minus one
wdata  in  DATA_W  write data for current beat
ready  out  1  idle, request accepted this cycle if en=1
rdata  out  DATA_W  read data; valid when rvalid=1
rvalid  out  1  one-cycle pulse per read beat
wack  out  1  one-cycle pulse per committed write beat; host presents next beat's wdata on the following cycle
done  out  1  one-cycle pulse at transaction end
err  out  1  one-cycle pulse, request rejected, no memory change

Behaviour:
- Reset (reset=0, async): state=IDLE; ready=1; rvalid=wack=done=err=0; rdata=0; beat and wait counters=0. Memory array is not cleared.
- Word index = addr[OFS_W +: IDX_W]. Upper address bits are ignored (aliasing). Burst index increments by 1 per beat, wrapping DEPTH-1 -> 0.
- Byte lane k of a word is data[8k+7:8k], little-endian.
- IDLE: ready=1. On en=1, latch rd_wr, wr_size, addr, burst_len, wdata; ready drops the next cycle.
- Validity check at acceptance:
  - Write with wr_size!=0 and burst_len!=0 -> error.
  - Write with addr[OFS_W-1:0]+wr_size > BYTES -> error.
  - Write with wr_size=0 and addr[OFS_W-1:0]!=0 -> error.
  - Error path: ERR state for 1 cycle, err=1 and done=1 together, then IDLE.
  - Reads ignore addr[OFS_W-1:0] and wr_size; never an error.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, ERR.
- RD: wait counter runs WAIT_CYCLES+1 cycles. On the last cycle, rdata<=mem[idx] and rvalid=1 the following cycle. If beats remain, advance index and restart RD; else done pulses with the final rvalid, then IDLE.
- WR (full word): wait counter runs WAIT_CYCLES+1 cycles. On the last cycle, mem[idx]<=current wdata and wack=1 the next cycle. Wdata for beat n+1 is sampled on the cycle after wack for beat n (the first WR cycle of beat n+1). Last beat: done with wack, then IDLE.
- Sub-word write:
  - RMW_RD: read mem[idx] into a merge register, WAIT_CYCLES+1 cycles.
  - RMW_WR: replace lanes offset..offset+wr_size-1 with wdata lanes 0..wr_size-1, write back over WAIT_CYCLES+1 cycles.
  - Then wack+done, then IDLE. Other lanes are preserved.
- Latency from acceptance cycle to response pulse:
  - Single read: WAIT_CYCLES+2 cycles.
  - Full-word write: WAIT_CYCLES+2 cycles.
  - Sub-word write: 2*WAIT_CYCLES+3 cycles.
  - Burst beats are back-to-back at WAIT_CYCLES+1 cycles each.
- en while ready=0 is ignored; no queueing.
- Reset asserted mid-transaction: immediate IDLE. A word whose commit cycle has not occurred is unchanged; earlier burst beats remain written.
- rdata holds its last value between reads.

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x40 (wr_size=0, burst_len=0), then read 0x40 -> wack 4 cycles after acceptance; rvalid 4 cycles after acceptance with rdata=0xDEADBEEF; done coincident with each.
- Preload 0x11223344 at 0x80; write wr_size=2, addr 0x81, wdata=0x0000AABB -> done at cycle 7; read 0x80 returns 0x11AABB44.
- Burst write 4 beats at 0x100, wdata 1,2,3,4 changed after each wack; burst read 4 beats -> 4 rvalid pulses 3 cycles apart, data 1,2,3,4, done on the 4th.
- Burst starting at word DEPTH-2, 4 beats -> writes words DEPTH-2, DEPTH-1, 0, 1; read-back confirms wrap.
- Error cases, each pulsing err=done=1 for 1 cycle and leaving memory unchanged:
  - wr_size=3 at addr offset 2.
  - wr_size=0 at addr 0x42.
  - wr_size=1 with burst_len=2.
- Assert reset during RMW_WR of a byte write to 0x80 -> outputs at reset values immediately, ready=1; read shows the old word 0x11223344.
